// File: rtl/load_ext_pipe_pkg.sv
// Shared load-extension definitions: mode and exception encodings reused by
// the decoder, CP0 and the load extender.
package ext_pkg;

  localparam int MODE_W = 3;
  localparam int EXC_W  = 2;

  typedef enum logic [MODE_W-1:0] {
    EXT_FULL   = 3'd0,
    EXT_HALF_U = 3'd1,
    EXT_HALF_S = 3'd2,
    EXT_BYTE_U = 3'd3,
    EXT_BYTE_S = 3'd4,
    EXT_WORD_U = 3'd5,
    EXT_WORD_S = 3'd6,
    EXT_RSVD   = 3'd7
  } ext_mode_e;

  // Code 3 is left unassigned for future use.
  typedef enum logic [EXC_W-1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_RI   = 2'd2
  } ext_exc_e;

  function automatic int unsigned off_width(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_ext_pipe_if.sv
// Input/output handshake bundle of the load extender; master drives loads in
// and accepts results, slave is the extender itself.
interface load_ext_pipe_if
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);

  localparam int OFF_W = off_width(DATA_W);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_addr_lo;
  logic [MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [EXC_W-1:0]  out_exc;

  modport master (
    output flush, in_valid, in_data, in_addr_lo, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_exc
  );

  modport slave (
    input  flush, in_valid, in_data, in_addr_lo, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_exc
  );

endinterface

// File: rtl/load_ext_pipe_lane_sel.sv
// Combinational lane selector: picks the addressed byte/half/word lane of the
// raw read word, extends it, and flags reserved or misaligned accesses.
module ext_lane_sel
  import ext_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = off_width(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0] o_data,
  output logic [EXC_W-1:0]  o_exc
);

  localparam bit HAS_WORD = (DATA_W == 64);

  ext_mode_e         w_mode;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_ext;
  logic              w_ri;
  logic              w_adel;

  assign w_mode = ext_mode_e'(i_mode);

  // Shifting by the byte offset puts every aligned lane at bit 0.
  assign w_lane = i_data >> {i_off, 3'b000};

  always_comb begin
    w_ri   = 1'b0;
    w_adel = 1'b0;
    w_ext  = '0;
    case (w_mode)
      EXT_FULL: begin
        w_adel = |i_off;
        w_ext  = i_data;
      end
      EXT_HALF_U: begin
        w_adel = i_off[0];
        w_ext  = DATA_W'(w_lane[15:0]);
      end
      EXT_HALF_S: begin
        w_adel = i_off[0];
        w_ext  = DATA_W'($signed(w_lane[15:0]));
      end
      EXT_BYTE_U: begin
        w_ext  = DATA_W'(w_lane[7:0]);
      end
      EXT_BYTE_S: begin
        w_ext  = DATA_W'($signed(w_lane[7:0]));
      end
      EXT_WORD_U: begin
        w_ri   = !HAS_WORD;
        w_adel = |i_off[1:0];
        w_ext  = DATA_W'(w_lane[31:0]);
      end
      EXT_WORD_S: begin
        w_ri   = !HAS_WORD;
        w_adel = |i_off[1:0];
        w_ext  = DATA_W'($signed(w_lane[31:0]));
      end
      default: begin
        w_ri   = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_data = '0;
    o_exc  = EXC_NONE;
    if (w_ri) begin
      o_exc = EXC_RI;
    end else if (w_adel) begin
      o_exc = EXC_ADEL;
    end else begin
      o_data = w_ext;
    end
  end

endmodule

// File: rtl/load_ext_pipe.sv
// Load-data extender with a registered two-entry skid output stage between
// the data-memory read port and the W-stage write path.
module load_ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input logic            clk,
  input logic            reset,
  load_ext_pipe_if.slave bus
);

  logic [DATA_W-1:0] w_ext_data;
  logic [EXC_W-1:0]  w_ext_exc;
  logic              w_push;
  logic              w_pop;

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [TAG_W-1:0]  r_main_tag;
  logic [EXC_W-1:0]  r_main_exc;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [TAG_W-1:0]  r_skid_tag;
  logic [EXC_W-1:0]  r_skid_exc;
  logic              r_in_ready;

  ext_lane_sel #(
    .DATA_W (DATA_W)
  ) u_lane_sel (
    .i_data (bus.in_data),
    .i_off  (bus.in_addr_lo),
    .i_mode (bus.in_mode),
    .o_data (w_ext_data),
    .o_exc  (w_ext_exc)
  );

  assign w_pop  = r_main_valid & bus.out_ready;
  assign w_push = bus.in_valid & bus.in_ready;

  // r_in_ready mirrors !r_skid_valid, so in_ready never depends on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_main_tag   <= '0;
      r_main_exc   <= '0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_pop) begin
        r_main_data  <= r_skid_data;
        r_main_tag   <= r_skid_tag;
        r_main_exc   <= r_skid_exc;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_push) begin
      if (!r_main_valid || w_pop) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_ext_data;
        r_main_tag   <= bus.in_tag;
        r_main_exc   <= w_ext_exc;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_ext_data;
        r_skid_tag   <= bus.in_tag;
        r_skid_exc   <= w_ext_exc;
        r_in_ready   <= 1'b0;
      end
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = r_in_ready & ~reset;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_tag   = r_main_tag;
  assign bus.out_exc   = r_main_exc;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Self-checking bench for load_ext_pipe at DATA_W=32 and DATA_W=64 against a
// queue-based reference model of the extender and its two-deep output buffer.
module tb_load_ext_pipe;
  import ext_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_ext_pipe_if #(.DATA_W(32), .TAG_W(5)) bus32 ();
  load_ext_pipe_if #(.DATA_W(64), .TAG_W(5)) bus64 ();

  load_ext_pipe #(.DATA_W(32), .TAG_W(5)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  load_ext_pipe #(.DATA_W(64), .TAG_W(5)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic [1:0]  exc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  function automatic exp_t ref_ext(input int unsigned w, input logic [63:0] d,
                                   input logic [2:0] off, input logic [2:0] mode,
                                   input logic [4:0] tag);
    exp_t        r;
    int unsigned size;
    bit          sgn;
    bit          ri;
    logic [63:0] mask;
    logic [63:0] lane;
    r.tag = tag; r.data = '0; r.exc = 2'd0;
    ri = 1'b0; sgn = 1'b0; size = 1;
    case (mode)
      3'd0: size = w / 8;
      3'd1: size = 2;
      3'd2: begin size = 2; sgn = 1'b1; end
      3'd3: size = 1;
      3'd4: begin size = 1; sgn = 1'b1; end
      3'd5: begin size = 4; ri = (w == 32); end
      3'd6: begin size = 4; sgn = 1'b1; ri = (w == 32); end
      default: ri = 1'b1;
    endcase
    if (ri) begin r.exc = 2'd2; return r; end
    if ((off % size) != 0) begin r.exc = 2'd1; return r; end
    mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    lane = (d >> (8 * off)) & mask;
    if (sgn && lane[8 * size - 1]) lane = lane | ~mask;
    if (w == 32) lane[63:32] = '0;
    r.data = lane;
    return r;
  endfunction

  task automatic idle_inputs();
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_data = '0;
    bus32.in_addr_lo = '0; bus32.in_mode = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_data = '0;
    bus64.in_addr_lo = '0; bus64.in_mode = '0; bus64.in_tag = '0; bus64.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready32: got %b want 0", bus32.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data32: got %h want 0", bus32.out_data); end
    checks++; if (bus32.out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag32: got %h want 0", bus32.out_tag); end
    checks++; if (bus32.out_exc !== 2'h0) begin errors++; $display("FAIL reset_out_exc32: got %h want 0", bus32.out_exc); end
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid64: got %b want 0", bus64.out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready32: got %b want 1", bus32.in_ready); end
    checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready64: got %b want 1", bus64.in_ready); end
  endtask

  task automatic test_directed32();
    logic [31:0] d   [12] = '{32'h8000_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF,
                              32'h807F_01FF, 32'h807F_01FF, 32'h807F_01FF, 32'h807F_01FF,
                              32'h8000_1234, 32'h8000_1234, 32'h8000_1234, 32'h807F_01FF};
    int unsigned off [12] = '{0, 2, 2, 3, 0, 1, 2, 3, 0, 1, 0, 3};
    int unsigned mode[12] = '{0, 2, 1, 2, 4, 4, 4, 4, 5, 0, 7, 3};
    logic [31:0] ed  [12] = '{32'h8000_1234, 32'hFFFF_8001, 32'h0000_8001, 32'h0,
                              32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_007F, 32'hFFFF_FF80,
                              32'h0, 32'h0, 32'h0, 32'h0000_0080};
    logic [1:0]  ee  [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0,
                              2'd2, 2'd1, 2'd2, 2'd0};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus32.in_valid = 1'b1; bus32.in_data = d[i];
      bus32.in_addr_lo = 2'(off[i]); bus32.in_mode = 3'(mode[i]); bus32.in_tag = 5'(i + 3);
      @(posedge clk); #1;
      checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL dir32_valid[%0d]: got %b want 1", i, bus32.out_valid); end
      checks++; if (bus32.out_data !== ed[i]) begin errors++; $display("FAIL dir32_data[%0d]: got %h want %h", i, bus32.out_data, ed[i]); end
      checks++; if (bus32.out_exc !== ee[i]) begin errors++; $display("FAIL dir32_exc[%0d]: got %0d want %0d", i, bus32.out_exc, ee[i]); end
      checks++; if (bus32.out_tag !== 5'(i + 3)) begin errors++; $display("FAIL dir32_tag[%0d]: got %0d want %0d", i, bus32.out_tag, i + 3); end
    end
    bus32.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL dir32_drain: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_directed64();
    int unsigned off [8] = '{4, 2, 4, 0, 6, 1, 0, 7};
    int unsigned mode[8] = '{6, 6, 5, 0, 2, 0, 7, 4};
    logic [63:0] ed  [8] = '{64'hFFFF_FFFF_9000_0000, 64'h0, 64'h0000_0000_9000_0000,
                             64'h9000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_9000, 64'h0,
                             64'h0, 64'hFFFF_FFFF_FFFF_FF90};
    logic [1:0]  ee  [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus64.in_valid = 1'b1; bus64.in_data = 64'h9000_0000_0000_0001;
      bus64.in_addr_lo = 3'(off[i]); bus64.in_mode = 3'(mode[i]); bus64.in_tag = 5'(i + 17);
      @(posedge clk); #1;
      checks++; if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL dir64_valid[%0d]: got %b want 1", i, bus64.out_valid); end
      checks++; if (bus64.out_data !== ed[i]) begin errors++; $display("FAIL dir64_data[%0d]: got %h want %h", i, bus64.out_data, ed[i]); end
      checks++; if (bus64.out_exc !== ee[i]) begin errors++; $display("FAIL dir64_exc[%0d]: got %0d want %0d", i, bus64.out_exc, ee[i]); end
      checks++; if (bus64.out_tag !== 5'(i + 17)) begin errors++; $display("FAIL dir64_tag[%0d]: got %0d want %0d", i, bus64.out_tag, i + 17); end
    end
    bus64.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL dir64_drain: got %b want 0", bus64.out_valid); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] d   [4];
    logic [2:0]  md  [4] = '{3'd0, 3'd2, 3'd4, 3'd1};
    exp_t        e   [4];
    int          sent = 0;
    int          recv = 0;
    int          c    = 0;
    bit          acc;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom();
      e[i] = ref_ext(32, {32'h0, d[i]}, 3'd0, md[i], 5'(i + 9));
    end
    while (recv < 4 && c < 30) begin
      bus32.out_ready = (c >= 3);
      bus32.in_valid  = (sent < 4);
      if (sent < 4) begin
        bus32.in_data = d[sent]; bus32.in_addr_lo = '0;
        bus32.in_mode = md[sent]; bus32.in_tag = 5'(sent + 9);
      end
      @(negedge clk);
      if (c == 1) begin
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_c1: got %b want 1", bus32.in_ready); end
      end
      if (c == 2) begin
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus32.in_ready); end
        checks++; if (bus32.out_data !== e[0].data[31:0]) begin errors++; $display("FAIL bp_stall_data: got %h want %h", bus32.out_data, e[0].data[31:0]); end
      end
      acc = bus32.in_valid && bus32.in_ready;
      if (bus32.out_valid && bus32.out_ready) begin
        checks++; if (bus32.out_data !== e[recv].data[31:0] || bus32.out_tag !== e[recv].tag)
          begin errors++; $display("FAIL bp_order[%0d]: got %h/%0d want %h/%0d", recv, bus32.out_data, bus32.out_tag, e[recv].data[31:0], e[recv].tag); end
        recv++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
      c++;
    end
    checks++; if (recv != 4) begin errors++; $display("FAIL bp_timeout: got %0d outputs want 4", recv); end
    bus32.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_flush();
    exp_t ed;
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_data = 32'h1111_2222; bus32.in_mode = 3'd0; bus32.in_addr_lo = '0; bus32.in_tag = 5'd1;
    @(posedge clk); #1;
    bus32.in_data = 32'h3333_4444; bus32.in_tag = 5'd2;
    @(posedge clk); #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got %b want 0", bus32.in_ready); end
    bus32.flush = 1'b1; bus32.in_data = 32'h5555_6666; bus32.in_tag = 5'd3;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b want 1", bus32.in_ready); end
    bus32.flush = 1'b0; bus32.in_data = 32'h0000_80F0; bus32.in_mode = 3'd4; bus32.in_addr_lo = 2'd0; bus32.in_tag = 5'd4;
    ed = ref_ext(32, 64'h0000_80F0, 3'd0, 3'd4, 5'd4);
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b1 || bus32.out_data !== ed.data[31:0])
      begin errors++; $display("FAIL flush_refill: got %b/%h want 1/%h", bus32.out_valid, bus32.out_data, ed.data[31:0]); end
    bus32.flush = 1'b1; bus32.in_data = 32'h7777_8888; bus32.in_tag = 5'd5;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_push: got %b want 0", bus32.out_valid); end
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   pop;
    bit   push;
    q32.delete(); q64.delete();
    for (int n = 0; n < 400; n++) begin
      bus32.in_valid = ($urandom_range(0, 3) != 0); bus32.in_data = $urandom();
      bus32.in_addr_lo = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
      bus32.in_mode = 3'($urandom_range(0, 7)); bus32.in_tag = 5'($urandom());
      bus32.out_ready = ($urandom_range(0, 2) != 0); bus32.flush = ($urandom_range(0, 19) == 0);
      bus64.in_valid = ($urandom_range(0, 3) != 0); bus64.in_data = {$urandom(), $urandom()};
      bus64.in_addr_lo = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
      bus64.in_mode = 3'($urandom_range(0, 7)); bus64.in_tag = 5'($urandom());
      bus64.out_ready = ($urandom_range(0, 2) != 0); bus64.flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++; if (bus32.in_ready !== (q32.size() < 2)) begin errors++; $display("FAIL rnd32_ready[%0d]: got %b want %b", n, bus32.in_ready, q32.size() < 2); end
      checks++; if (bus32.out_valid !== (q32.size() > 0)) begin errors++; $display("FAIL rnd32_valid[%0d]: got %b want %b", n, bus32.out_valid, q32.size() > 0); end
      if (q32.size() > 0) begin
        checks++; if (bus32.out_data !== q32[0].data[31:0] || bus32.out_tag !== q32[0].tag || bus32.out_exc !== q32[0].exc)
          begin errors++; $display("FAIL rnd32_out[%0d]: got %h/%0d/%0d want %h/%0d/%0d", n, bus32.out_data, bus32.out_tag, bus32.out_exc, q32[0].data[31:0], q32[0].tag, q32[0].exc); end
      end
      checks++; if (bus64.in_ready !== (q64.size() < 2)) begin errors++; $display("FAIL rnd64_ready[%0d]: got %b want %b", n, bus64.in_ready, q64.size() < 2); end
      checks++; if (bus64.out_valid !== (q64.size() > 0)) begin errors++; $display("FAIL rnd64_valid[%0d]: got %b want %b", n, bus64.out_valid, q64.size() > 0); end
      if (q64.size() > 0) begin
        checks++; if (bus64.out_data !== q64[0].data || bus64.out_tag !== q64[0].tag || bus64.out_exc !== q64[0].exc)
          begin errors++; $display("FAIL rnd64_out[%0d]: got %h/%0d/%0d want %h/%0d/%0d", n, bus64.out_data, bus64.out_tag, bus64.out_exc, q64[0].data, q64[0].tag, q64[0].exc); end
      end
      if (bus32.flush) q32.delete();
      else begin
        pop  = (q32.size() > 0) && bus32.out_ready;
        push = bus32.in_valid && (q32.size() < 2);
        e = ref_ext(32, {32'h0, bus32.in_data}, {1'b0, bus32.in_addr_lo}, bus32.in_mode, bus32.in_tag);
        if (pop) void'(q32.pop_front());
        if (push) q32.push_back(e);
      end
      if (bus64.flush) q64.delete();
      else begin
        pop  = (q64.size() > 0) && bus64.out_ready;
        push = bus64.in_valid && (q64.size() < 2);
        e = ref_ext(64, bus64.in_data, bus64.in_addr_lo, bus64.in_mode, bus64.in_tag);
        if (pop) void'(q64.pop_front());
        if (push) q64.push_back(e);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_data = 32'hDEAD_BEEF; bus32.in_mode = 3'd0; bus32.in_addr_lo = '0; bus32.in_tag = 5'd21;
    @(posedge clk); #1;
    bus32.in_data = 32'hCAFE_F00D; bus32.in_tag = 5'd22;
    @(posedge clk); #1;
    reset = 1'b1; bus32.flush = 1'b1; bus32.in_data = 32'h1234_5678; bus32.in_tag = 5'd23;
    @(posedge clk); #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", bus32.out_data); end
    checks++; if (bus32.out_tag !== 5'h0) begin errors++; $display("FAIL rstmid_tag: got %h want 0", bus32.out_tag); end
    checks++; if (bus32.out_exc !== 2'h0) begin errors++; $display("FAIL rstmid_exc: got %h want 0", bus32.out_exc); end
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_hold: got %b want 0", bus32.in_ready); end
    reset = 1'b0; bus32.flush = 1'b0; bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", bus32.in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed32();
    test_directed64();
    test_back_pressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
